// File: rtl/jtopl_wrseq_pkg.sv
// Shared types and constants for the OPL write scheduler.
package jtopl_wrseq_pkg;

  // Sequencer states: address strobe, address recovery, data strobe, data recovery.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASTB  = 3'd1,
    AWAIT = 3'd2,
    DSTB  = 3'd3,
    DWAIT = 3'd4
  } state_t;

  // Values driven on the core's addr pin to select the target port.
  localparam logic ADDR_PORT = 1'b0;
  localparam logic DATA_PORT = 1'b1;

  // One queued register write, as stored in the FIFO.
  typedef struct packed {
    logic [7:0] reg_idx;
    logic [7:0] data;
  } wr_entry_t;

endpackage

// File: rtl/jtopl_wrseq_if.sv
// Request handshake between a register-write requester and the scheduler.
interface jtopl_wrseq_if;
  import jtopl_wrseq_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_reg;
  logic [7:0] req_data;

  modport master (output req_valid, output req_reg, output req_data, input req_ready);
  modport slave  (input req_valid, input req_reg, input req_data, output req_ready);
endinterface

// File: rtl/jtopl_wrseq_fifo.sv
// Synchronous first-word-fall-through FIFO of queued register writes.
// full/empty/level are registered; flush empties the queue and drops a coincident push.
module jtopl_wrseq_fifo
  import jtopl_wrseq_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wr_entry_t din,
  output wr_entry_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] level
);

  localparam int unsigned DEPTH = 1 << AW;

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Next occupancy, used to register level/full/empty together.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (do_push && !do_pop) begin
      level_nxt = level + 1'b1;
    end else if (!do_push && do_pop) begin
      level_nxt = level - 1'b1;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone define validity.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtopl_wrseq.sv
// Host-side write scheduler for the OPL core: queues (reg, data) writes and replays
// each as an address-port then a data-port write, honouring the chip's recovery times
// counted in cen ticks.
module jtopl_wrseq
  import jtopl_wrseq_pkg::*;
#(
  parameter int unsigned AW        = 4,
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  jtopl_wrseq_if.slave  req,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          opl_addr,
  output logic [7:0]    opl_din,
  output logic          opl_cs_n,
  output logic          opl_wr_n
);

  localparam logic [7:0] ADDR_CNT = 8'(ADDR_WAIT);
  localparam logic [7:0] DATA_CNT = 8'(DATA_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] hold_data;

  wr_entry_t  fifo_head;
  wr_entry_t  push_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // A flush in the same cycle drops the request, so it is not acknowledged.
  assign req.req_ready = !fifo_full && !flush;
  assign push          = req.req_valid && req.req_ready;
  assign push_entry    = '{reg_idx: req.req_reg, data: req.req_data};
  assign busy          = (state != IDLE) || (level != '0);

  jtopl_wrseq_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Pop from IDLE, or on the last data-recovery tick so the next address strobe follows directly.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == DWAIT && cen && wait_cnt == 8'd1) begin
        pop = 1'b1;
      end
    end
  end

  // Sequencer: bus values are loaded one cycle before the strobe falls, the strobe is
  // released on the first cen edge it sees, and the recovery counter then runs on cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      hold_data <= '0;
      opl_addr  <= ADDR_PORT;
      opl_din   <= '0;
      opl_cs_n  <= 1'b1;
      opl_wr_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold_data <= fifo_head.data;
            opl_addr  <= ADDR_PORT;
            opl_din   <= fifo_head.reg_idx;
            state     <= ASTB;
          end
        end
        ASTB: begin
          if (opl_cs_n) begin
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
          end else if (cen) begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            wait_cnt <= ADDR_CNT;
            state    <= AWAIT;
          end
        end
        AWAIT: begin
          if (cen) begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == 8'd1) begin
              opl_addr <= DATA_PORT;
              opl_din  <= hold_data;
              state    <= DSTB;
            end
          end
        end
        DSTB: begin
          if (opl_cs_n) begin
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
          end else if (cen) begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            wait_cnt <= DATA_CNT;
            state    <= DWAIT;
          end
        end
        DWAIT: begin
          if (cen) begin
            wait_cnt <= wait_cnt - 1'b1;
            if (wait_cnt == 8'd1) begin
              if (pop) begin
                hold_data <= fifo_head.data;
                opl_addr  <= ADDR_PORT;
                opl_din   <= fifo_head.reg_idx;
                state     <= ASTB;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Directed testbench for jtopl_wrseq: bus timing, ordering, full/flush/reset handling
// and a small register model of the OPL core fed from the observed strobes.
module tb_jtopl_wrseq;
  import jtopl_wrseq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] level;
  logic       busy;
  logic       opl_addr;
  logic [7:0] opl_din;
  logic       opl_cs_n;
  logic       opl_wr_n;

  jtopl_wrseq_if req_if();

  jtopl_wrseq #(.AW(4), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .req      (req_if),
    .flush    (flush),
    .level    (level),
    .busy     (busy),
    .opl_addr (opl_addr),
    .opl_din  (opl_din),
    .opl_cs_n (opl_cs_n),
    .opl_wr_n (opl_wr_n)
  );

  always #5 clk = ~clk;

  // cen pattern: 0 = stuck low, N = high on every Nth clock.
  int cen_div = 1;
  int phase   = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = phase + 1;
      if (cen_div == 0) cen = 1'b0;
      else              cen = ((phase % cen_div) == 0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- strobe monitor and core register model ----------------
  int         cen_cnt = 0;
  bit         last_cen = 1'b0;
  bit         rst_seen = 1'b1;
  bit         prev_cs = 1'b1;
  logic [7:0] prev_din = '0;
  logic       prev_addr = 1'b0;
  int         rel_cnt = 0;
  int         fall_cnt = 0;
  logic [7:0] fall_din = '0;
  logic       fall_addr = 1'b0;
  int         last_kind = 0;   // 0 none, 1 address strobe, 2 data strobe
  bit         window_viol = 1'b0;
  int         mon_gap;
  int         ev_n = 0;
  logic       ev_addr [128];
  logic [7:0] ev_din  [128];
  int         ev_gap  [128];
  int         ev_low  [128];
  bit         ev_pre  [128];
  bit         ev_hold [128];
  logic [7:0] core_idx = '0;
  logic [7:0] core_regs [256];

  // cen ticks and reset as seen by the DUT at each active edge.
  always @(posedge clk) begin
    cen_cnt  <= cen_cnt + (cen ? 1 : 0);
    last_cen <= cen;
    rst_seen <= rst;
  end

  // Strobe edges are observed mid-cycle, where all DUT outputs are settled.
  always @(negedge clk) begin
    if (rst_seen) begin
      prev_cs   <= 1'b1;
      last_kind <= 0;
    end else begin
      if (prev_cs && !opl_cs_n && ev_n < 128) begin
        mon_gap = cen_cnt - rel_cnt - (last_cen ? 1 : 0);
        ev_addr[ev_n] <= opl_addr;
        ev_din[ev_n]  <= opl_din;
        ev_gap[ev_n]  <= mon_gap;
        ev_pre[ev_n]  <= (opl_din == prev_din) && (opl_addr == prev_addr);
        fall_cnt  <= cen_cnt;
        fall_din  <= opl_din;
        fall_addr <= opl_addr;
        if (opl_addr == DATA_PORT) begin
          if (last_kind != 1 || mon_gap < 12) window_viol <= 1'b1;
          core_regs[core_idx] <= opl_din;
          last_kind <= 2;
        end else begin
          if (last_kind == 2 && mon_gap < 84) window_viol <= 1'b1;
          core_idx  <= opl_din;
          last_kind <= 1;
        end
      end else if (!prev_cs && opl_cs_n && ev_n < 128) begin
        ev_low[ev_n]  <= cen_cnt - fall_cnt;
        ev_hold[ev_n] <= (opl_din == fall_din) && (opl_addr == fall_addr);
        rel_cnt <= cen_cnt;
        ev_n    <= ev_n + 1;
      end
      prev_cs <= opl_cs_n;
    end
    prev_din  <= opl_din;
    prev_addr <= opl_addr;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic set_req(input logic v, input logic [7:0] r, input logic [7:0] d);
    req_if.req_valid = v;
    req_if.req_reg   = r;
    req_if.req_data  = d;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] t2_din [6];
  int         t2_gap [6];
  int         base;

  initial begin
    t2_din = '{8'h40, 8'h3F, 8'h60, 8'hF0, 8'h80, 8'h77};
    t2_gap = '{0, 12, 84, 12, 84, 12};
    set_req(1'b0, 8'h00, 8'h00);
    cen_div = 1;
    rst = 1'b1;
    tick(3);

    // Reset state
    check("rst level", 32'(level), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cs_n", 32'(opl_cs_n), 32'd1);
    check("rst wr_n", 32'(opl_wr_n), 32'd1);
    check("rst addr", 32'(opl_addr), 32'd0);
    check("rst din", 32'(opl_din), 32'd0);
    check("rst ready", 32'(req_if.req_ready), 32'd1);
    rst = 1'b0;

    // 1: single write, cen always high
    set_req(1'b1, 8'h20, 8'h01);
    tick();
    set_req(1'b0, 8'h00, 8'h00);
    check("t1 level after push", 32'(level), 32'd1);
    check("t1 busy after push", 32'(busy), 32'd1);
    tick();
    check("t1 setup din", 32'(opl_din), 32'h20);
    check("t1 setup addr", 32'(opl_addr), 32'd0);
    check("t1 setup cs_n", 32'(opl_cs_n), 32'd1);
    check("t1 level after pop", 32'(level), 32'd0);
    tick();
    check("t1 A cs_n", 32'(opl_cs_n), 32'd0);
    check("t1 A wr_n", 32'(opl_wr_n), 32'd0);
    check("t1 A din", 32'(opl_din), 32'h20);
    tick();
    check("t1 A release", 32'(opl_cs_n), 32'd1);
    tick(11);
    check("t1 await addr", 32'(opl_addr), 32'd0);
    check("t1 await cs_n", 32'(opl_cs_n), 32'd1);
    tick();
    check("t1 D setup addr", 32'(opl_addr), 32'd1);
    check("t1 D setup din", 32'(opl_din), 32'h01);
    check("t1 D setup cs_n", 32'(opl_cs_n), 32'd1);
    tick();
    check("t1 D cs_n", 32'(opl_cs_n), 32'd0);
    check("t1 D wr_n", 32'(opl_wr_n), 32'd0);
    tick();
    check("t1 D release", 32'(opl_wr_n), 32'd1);
    tick(83);
    check("t1 busy in dwait", 32'(busy), 32'd1);
    tick();
    check("t1 busy falls", 32'(busy), 32'd0);
    check("t1 strobes", 32'(ev_n), 32'd2);

    // 2: cen every 4th clock, three writes back-to-back
    cen_div = 4;
    tick(2);
    base = ev_n;
    set_req(1'b1, 8'h40, 8'h3F);
    tick();
    set_req(1'b1, 8'h60, 8'hF0);
    tick();
    set_req(1'b1, 8'h80, 8'h77);
    tick();
    set_req(1'b0, 8'h00, 8'h00);
    wait_idle("t2 drain", 3000);
    check("t2 strobes", 32'(ev_n - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2 addr[%0d]", i), 32'(ev_addr[base+i]), 32'(i % 2));
      check($sformatf("t2 din[%0d]", i), 32'(ev_din[base+i]), 32'(t2_din[i]));
      check($sformatf("t2 low ticks[%0d]", i), 32'(ev_low[base+i]), 32'd1);
      check($sformatf("t2 setup[%0d]", i), 32'(ev_pre[base+i]), 32'd1);
      check($sformatf("t2 hold[%0d]", i), 32'(ev_hold[base+i]), 32'd1);
      if (i > 0) check($sformatf("t2 gap[%0d]", i), 32'(ev_gap[base+i]), 32'(t2_gap[i]));
    end

    // 3: fill with cen stuck low, refuse overflow, then drain in order
    cen_div = 0;
    tick(2);
    base = ev_n;
    for (int k = 0; k < 17; k++) begin
      set_req(1'b1, 8'h10 + 8'(k), 8'hC0 ^ 8'(k));
      tick();
    end
    set_req(1'b0, 8'h00, 8'h00);
    check("t3 level full", 32'(level), 32'd16);
    check("t3 ready at full", 32'(req_if.req_ready), 32'd0);
    check("t3 no strobe release", 32'(ev_n - base), 32'd0);
    set_req(1'b1, 8'hEE, 8'hEE);
    tick(3);
    set_req(1'b0, 8'h00, 8'h00);
    check("t3 level after refused push", 32'(level), 32'd16);
    cen_div = 1;
    wait_idle("t3 drain", 6000);
    check("t3 strobes", 32'(ev_n - base), 32'd34);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("t3 write[%0d]", k),
            {16'd0, ev_din[base+2*k], ev_din[base+2*k+1]},
            {16'd0, 8'h10 + 8'(k), 8'hC0 ^ 8'(k)});
    end

    // 4: flush with five queued and one in address recovery
    tick(2);
    base = ev_n;
    for (int k = 0; k < 6; k++) begin
      set_req(1'b1, 8'h50 + 8'(k), 8'h60 + 8'(k));
      tick();
    end
    check("t4 level queued", 32'(level), 32'd5);
    flush = 1'b1;
    set_req(1'b1, 8'h99, 8'h99);
    #1;
    check("t4 ready during flush", 32'(req_if.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    set_req(1'b0, 8'h00, 8'h00);
    check("t4 level after flush", 32'(level), 32'd0);
    check("t4 busy in flight", 32'(busy), 32'd1);
    wait_idle("t4 drain", 1000);
    check("t4 strobes", 32'(ev_n - base), 32'd2);
    check("t4 A din", 32'(ev_din[base]), 32'h50);
    check("t4 D addr", 32'(ev_addr[base+1]), 32'd1);
    check("t4 D din", 32'(ev_din[base+1]), 32'h60);

    // 5: reset pulse while the data strobe is low
    set_req(1'b1, 8'h21, 8'h55);
    tick();
    set_req(1'b1, 8'h23, 8'h56);
    tick();
    set_req(1'b0, 8'h00, 8'h00);
    tick(15);
    check("t5 in data strobe", 32'(opl_cs_n), 32'd0);
    check("t5 data port", 32'(opl_addr), 32'd1);
    check("t5 level queued", 32'(level), 32'd1);
    rst = 1'b1;
    tick();
    check("t5 rst cs_n", 32'(opl_cs_n), 32'd1);
    check("t5 rst wr_n", 32'(opl_wr_n), 32'd1);
    check("t5 rst level", 32'(level), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    base = ev_n;
    set_req(1'b1, 8'h22, 8'h66);
    tick();
    set_req(1'b0, 8'h00, 8'h00);
    tick();
    check("t5 new setup din", 32'(opl_din), 32'h22);
    check("t5 new setup addr", 32'(opl_addr), 32'd0);
    tick();
    check("t5 new A cs_n", 32'(opl_cs_n), 32'd0);
    wait_idle("t5 drain", 1000);
    check("t5 strobes", 32'(ev_n - base), 32'd2);
    check("t5 D din", 32'(ev_din[base+1]), 32'h66);

    // 6: core register model and recovery windows
    cen_div = 2;
    tick(2);
    set_req(1'b1, 8'hA0, 8'h44);
    tick();
    set_req(1'b1, 8'hB0, 8'h31);
    tick();
    set_req(1'b0, 8'h00, 8'h00);
    wait_idle("t6 drain", 2000);
    check("t6 core A0", 32'(core_regs[8'hA0]), 32'h44);
    check("t6 core B0", 32'(core_regs[8'hB0]), 32'h31);
    check("t6 wait windows", 32'(window_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
